// File: rtl/bram_test_pkg.sv
// Shared definitions for the BRAM test path: state encoding, default widths
// and the counting-pattern function used by both write generator and checker.
package bram_test_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int AW_DEFAULT = 20;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_CHECK = S_CHECK,
        ST_DRAIN = S_DRAIN,
        ST_DONE  = S_DONE
    } state_t;

    // Pattern word stored at an address; caller truncates the result to its DW.
    function automatic logic [31:0] expected_word(input logic [31:0] addr,
                                                  input logic [31:0] offset,
                                                  input int unsigned dw);
        logic [31:0] mask;
        mask = (dw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 32'd1);
        return (addr + offset) & mask;
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Delay line carrying {valid, addr, expected} to line up with BRAM read data.
// Latency: RD_LAT cycles from push to pop.
// Backpressure: none; always shifts, flush_n clears all valid bits synchronously.
module rd_lat_pipe #(
    parameter int RD_LAT = 1,
    parameter int AW     = 20,
    parameter int DW     = 16
) (
    input  logic          clk,
    input  logic          flush_n,
    input  logic          push_vld,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_exp,
    output logic          pop_vld,
    output logic [AW-1:0] pop_addr,
    output logic [DW-1:0] pop_exp
);

    logic [RD_LAT-1:0] vld_q;
    logic [AW-1:0]     addr_q [RD_LAT];
    logic [DW-1:0]     exp_q  [RD_LAT];

    always_ff @(posedge clk) begin
        if (!flush_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= push_vld;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload needs no reset: it is only consumed alongside its valid bit.
    always_ff @(posedge clk) begin
        addr_q[0] <= push_addr;
        exp_q[0]  <= push_exp;
        for (int i = 1; i < RD_LAT; i++) begin
            addr_q[i] <= addr_q[i-1];
            exp_q[i]  <= exp_q[i-1];
        end
    end

    assign pop_vld  = vld_q[RD_LAT-1];
    assign pop_addr = addr_q[RD_LAT-1];
    assign pop_exp  = exp_q[RD_LAT-1];

endmodule

// File: rtl/bram_readback_checker.sv
// Checks port-B BRAM reads against the stored counting pattern; reports pass/fail.
// Latency: each read compared RD_LAT cycles after issue; done one cycle after last compare.
// Backpressure: none; purely observes the read port, excess or out-of-run reads are ignored.
module bram_readback_checker
    import bram_test_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int AW          = AW_DEFAULT,
    parameter int NUM_WORDS   = 50,
    parameter int RD_LAT      = 1,
    parameter int DATA_OFFSET = 0,
    parameter int TIMEOUT     = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [15:0]   err_count,
    output logic [AW:0]   chk_count,
    output logic [AW-1:0] first_err_addr,
    output logic [DW-1:0] first_err_data,
    output logic [DW-1:0] first_err_exp
);

    localparam int          TW   = $clog2(TIMEOUT) + 1;
    localparam logic [AW:0] NW   = (AW+1)'(NUM_WORDS);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [AW:0]     issue_cnt;
    logic [TW-1:0]   idle_timer;
    logic            issue, cmp, mismatch;
    logic            run_clr, finish, abort;
    logic            pop_vld;
    logic [AW-1:0]   pop_addr;
    logic [DW-1:0]   pop_exp, push_exp;

    assign busy     = (state == ST_CHECK) || (state == ST_DRAIN);
    assign issue    = (state == ST_CHECK) && rd_en && (issue_cnt < NW);
    assign cmp      = busy && pop_vld;
    assign mismatch = cmp && (rd_data != pop_exp);
    assign push_exp = DW'(expected_word(32'(rd_addr), 32'(DATA_OFFSET), DW));

    rd_lat_pipe #(.RD_LAT(RD_LAT), .AW(AW), .DW(DW)) u_pipe (
        .clk       (clk),
        .flush_n   (rst && !abort),
        .push_vld  (issue),
        .push_addr (rd_addr),
        .push_exp  (push_exp),
        .pop_vld   (pop_vld),
        .pop_addr  (pop_addr),
        .pop_exp   (pop_exp)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        run_clr   = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt = ST_CHECK;
                    run_clr   = 1'b1;
                end
            end
            ST_CHECK: begin
                if (issue && (issue_cnt == NW - (AW+1)'(1))) begin
                    state_nxt = ST_DRAIN;
                end else if (!issue && !cmp && (idle_timer == TMAX)) begin
                    state_nxt = ST_DONE;
                    abort     = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Registered count already includes the final compare here.
                if (chk_count == NW) begin
                    state_nxt = ST_DONE;
                    finish    = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            chk_count      <= '0;
            issue_cnt      <= '0;
            idle_timer     <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            first_err_exp  <= '0;
        end else begin
            done <= finish || abort;
            if (run_clr) begin
                pass           <= 1'b0;
                timeout        <= 1'b0;
                err_count      <= '0;
                chk_count      <= '0;
                issue_cnt      <= '0;
                idle_timer     <= '0;
                first_err_addr <= '0;
                first_err_data <= '0;
                first_err_exp  <= '0;
            end else begin
                if (issue) issue_cnt <= issue_cnt + (AW+1)'(1);
                if (cmp)   chk_count <= chk_count + (AW+1)'(1);
                if (mismatch) begin
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                    // err_count saturates and never wraps, so zero marks the first miss.
                    if (err_count == 16'd0) begin
                        first_err_addr <= pop_addr;
                        first_err_data <= rd_data;
                        first_err_exp  <= pop_exp;
                    end
                end
                if (state == ST_CHECK) begin
                    if (issue || cmp)  idle_timer <= '0;
                    else if (!abort)   idle_timer <= idle_timer + TW'(1);
                end
                if (finish) pass <= (err_count == 16'd0);
                if (abort) begin
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_readback_checker.sv
// Directed bench: two checker instances (RD_LAT=1 and RD_LAT=3) fed by BRAM models,
// with a per-sample compare-cycle scoreboard and a per-run result scoreboard.
module tb_bram_readback_checker;

    localparam int DW = 16;
    localparam int AW = 20;

    typedef struct {
        logic pass;
        logic to;
        int   err;
        int   chk;
        int   fa;
        int   fd;
        int   fe;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          rd_en = 1'b0;
    logic          use3 = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic          start_a, en_a, start_b, en_b;
    logic [DW-1:0] dout_a, dout_b, s0_b, s1_b;
    logic          busy_a, done_a, pass_a, to_a, busy_b, done_b, pass_b, to_b;
    logic [15:0]   err_a, err_b;
    logic [AW:0]   chk_a, chk_b;
    logic [AW-1:0] fa_a, fa_b;
    logic [DW-1:0] fd_a, fd_b, fe_a, fe_b;

    logic          o_busy, o_done, o_pass, o_to;
    logic [15:0]   o_err;
    logic [AW:0]   o_chk;
    logic [AW-1:0] o_fa;
    logic [DW-1:0] o_fd, o_fe;

    logic [DW-1:0] mem [0:63];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    int            first_cyc, last_cyc, done_cyc;
    int            cmp_q[$];
    res_t          res_q[$];
    logic [AW:0]   prev_chk = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign start_a = start & ~use3;
    assign en_a    = rd_en & ~use3;
    assign start_b = start & use3;
    assign en_b    = rd_en & use3;

    always @(posedge clk) if (en_a) dout_a <= mem[rd_addr[5:0]];
    always @(posedge clk) begin
        if (en_b) s0_b <= mem[rd_addr[5:0]];
        s1_b   <= s0_b;
        dout_b <= s1_b;
    end

    bram_readback_checker #(.DW(DW), .AW(AW), .NUM_WORDS(50), .RD_LAT(1),
                            .DATA_OFFSET(0), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .rd_en(en_a), .rd_addr(rd_addr),
        .rd_data(dout_a), .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(to_a),
        .err_count(err_a), .chk_count(chk_a), .first_err_addr(fa_a),
        .first_err_data(fd_a), .first_err_exp(fe_a)
    );

    bram_readback_checker #(.DW(DW), .AW(AW), .NUM_WORDS(50), .RD_LAT(3),
                            .DATA_OFFSET(0), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rd_en(en_b), .rd_addr(rd_addr),
        .rd_data(dout_b), .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(to_b),
        .err_count(err_b), .chk_count(chk_b), .first_err_addr(fa_b),
        .first_err_data(fd_b), .first_err_exp(fe_b)
    );

    assign o_busy = use3 ? busy_b : busy_a;
    assign o_done = use3 ? done_b : done_a;
    assign o_pass = use3 ? pass_b : pass_a;
    assign o_to   = use3 ? to_b   : to_a;
    assign o_err  = use3 ? err_b  : err_a;
    assign o_chk  = use3 ? chk_b  : chk_a;
    assign o_fa   = use3 ? fa_b   : fa_a;
    assign o_fd   = use3 ? fd_b   : fd_a;
    assign o_fe   = use3 ? fe_b   : fe_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Each chk_count step must match the oldest outstanding issue's compare cycle.
    always @(negedge clk) begin
        if (32'(o_chk) == 32'(prev_chk) + 1) begin
            if (cmp_q.size() == 0) begin
                chk("cmp_without_issue", 32'(cmp_q.size()), 1);
            end else begin
                int e;
                e = cmp_q.pop_front();
                chk("cmp_cycle", cyc, e);
            end
        end
        prev_chk = o_chk;
    end

    task automatic push_res(input logic p, input logic t, input int e, input int c,
                            input int fa, input int fd, input int fe);
        res_t r;
        r.pass = p; r.to = t; r.err = e; r.chk = c; r.fa = fa; r.fd = fd; r.fe = fe;
        res_q.push_back(r);
    endtask

    task automatic do_start(input string name);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, "_busy_after_start"}, o_busy, 1);
        chk({name, "_pass_cleared"}, o_pass, 0);
        chk({name, "_timeout_cleared"}, o_to, 0);
        chk({name, "_chk_cleared"}, 32'(o_chk), 0);
    endtask

    task automatic issue_reads(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            rd_en   = 1'b1;
            rd_addr = AW'(i);
            cmp_q.push_back(cyc + 1 + (use3 ? 3 : 1));
            if (i == 0) first_cyc = cyc + 1;
            last_cyc = cyc + 1;
            @(negedge clk);
            rd_en = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        logic got;
        got = 1'b0;
        for (int n = 0; n < budget && !got; n++) begin
            @(negedge clk);
            if (o_done) got = 1'b1;
        end
        done_cyc = cyc;
        chk({name, "_done_seen"}, got, 1);
    endtask

    task automatic check_result(input string name);
        res_t r;
        if (res_q.size() == 0) begin
            chk({name, "_result_expected"}, 32'(res_q.size()), 1);
            return;
        end
        r = res_q.pop_front();
        chk({name, "_pass"}, o_pass, r.pass);
        chk({name, "_timeout"}, o_to, r.to);
        chk({name, "_err_count"}, 32'(o_err), r.err);
        chk({name, "_chk_count"}, 32'(o_chk), r.chk);
        chk({name, "_first_err_addr"}, 32'(o_fa), r.fa);
        chk({name, "_first_err_data"}, 32'(o_fd), r.fd);
        chk({name, "_first_err_exp"}, 32'(o_fe), r.fe);
        chk({name, "_cmp_q_drained"}, 32'(cmp_q.size()), 0);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, o_done, 0);
        chk({name, "_idle_after_done"}, o_busy, 0);
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < 64; i++) mem[i] = DW'(i);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_pass", o_pass, 0);
        chk("rst_timeout", o_to, 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_chk", 32'(o_chk), 0);
        chk("rst_first_addr", 32'(o_fa), 0);
        rst = 1'b1;
        @(negedge clk);

        // Clean run, RD_LAT=1, back-to-back
        push_res(1'b1, 1'b0, 0, 50, 0, 0, 0);
        do_start("clean");
        issue_reads(50, 0);
        wait_done("clean", 20);
        chk("clean_done_latency", done_cyc - first_cyc, 51);
        check_result("clean");

        // Single corrupted word at address 7
        mem[7] = 16'hBEEF;
        push_res(1'b0, 1'b0, 1, 50, 7, 16'hBEEF, 7);
        do_start("corrupt1");
        issue_reads(50, 0);
        wait_done("corrupt1", 20);
        check_result("corrupt1");
        mem[7] = 16'd7;

        // Two mismatches: first one must stick
        mem[3]  = 16'hAAAA;
        mem[20] = 16'h1234;
        push_res(1'b0, 1'b0, 2, 50, 3, 16'hAAAA, 3);
        do_start("corrupt2");
        issue_reads(50, 0);
        wait_done("corrupt2", 20);
        check_result("corrupt2");
        mem[3]  = 16'd3;
        mem[20] = 16'd20;

        // RD_LAT=3 instance, read every other cycle
        use3 = 1'b1;
        push_res(1'b1, 1'b0, 0, 50, 0, 0, 0);
        do_start("lat3");
        issue_reads(50, 1);
        wait_done("lat3", 20);
        chk("lat3_done_latency", done_cyc - last_cyc, 4);
        check_result("lat3");
        use3 = 1'b0;
        @(negedge clk);

        // Timeout: 10 reads then silence
        push_res(1'b0, 1'b1, 0, 10, 0, 0, 0);
        do_start("tmo");
        issue_reads(10, 0);
        wait_done("tmo", 60);
        chk("tmo_done_after_last_cmp", done_cyc - (last_cyc + 1), 16);
        check_result("tmo");

        // Reset while draining
        do_start("rstmid");
        issue_reads(50, 0);
        chk("rstmid_busy_in_drain", o_busy, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cmp_q.delete();
        chk("rstmid_busy", o_busy, 0);
        chk("rstmid_err", 32'(o_err), 0);
        chk("rstmid_chk", 32'(o_chk), 0);
        chk("rstmid_done", o_done, 0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (o_done) seen = 1'b1;
        end
        chk("rstmid_no_done_pulse", seen, 0);

        push_res(1'b1, 1'b0, 0, 50, 0, 0, 0);
        do_start("after_rst");
        issue_reads(50, 0);
        wait_done("after_rst", 20);
        check_result("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
